// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter feeding the source side of a 2-phase CDC handshake.
// One word in flight; re-arbitrates after the ack round-trip completes.
`default_nettype none

module cdc_tx_arbiter #(
    parameter int G_N_REQ     = 4,
    parameter int G_WIDTH     = 4,
    parameter int G_TIMEOUT   = 64,
    parameter int G_CNT_WIDTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [G_N_REQ-1:0]           i_req_valid,
    input  logic [G_N_REQ*G_WIDTH-1:0]   i_req_data,
    output logic [G_N_REQ-1:0]           o_req_ready,
    output logic                         o_valid_A,
    output logic [G_WIDTH-1:0]           o_data_A,
    input  logic                         i_ready_A,
    output logic [((G_N_REQ > 1) ? $clog2(G_N_REQ) : 1)-1:0] o_grant_id,
    output logic                         o_busy,
    output logic [G_CNT_WIDTH-1:0]       o_xfer_cnt,
    output logic                         o_timeout
);

    localparam int C_IDW = (G_N_REQ > 1) ? $clog2(G_N_REQ) : 1;
    localparam int C_TW  = $clog2(G_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [C_IDW-1:0]         last_q, last_d;
    logic [C_IDW-1:0]         grant_q, grant_d;
    logic [G_WIDTH-1:0]       data_q, data_d;
    logic                     valid_q, valid_d;
    logic [G_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [C_TW-1:0]          tmo_q, tmo_d;
    logic                     timeout_q, timeout_d;

    logic                     win_found;
    logic [C_IDW-1:0]         win_idx;
    logic [G_WIDTH-1:0]       win_data;
    logic [G_N_REQ-1:0]       win_onehot;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        int k;
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int i = 1; i <= G_N_REQ; i++) begin
            k = (int'(last_q) + i) % G_N_REQ;
            if (!win_found && i_req_valid[k]) begin
                win_found = 1'b1;
                win_idx   = C_IDW'(k);
            end
        end
    end

    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int k = 0; k < G_N_REQ; k++) begin
            if (C_IDW'(k) == win_idx) begin
                win_data      = i_req_data[k*G_WIDTH +: G_WIDTH];
                win_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        timeout_d   = timeout_q;
        o_req_ready = '0;

        case (state_q)
            IDLE: begin
                if (i_ready_A && win_found) begin
                    o_req_ready = win_onehot;
                    data_d      = win_data;
                    grant_d     = win_idx;
                    last_d      = win_idx;
                    valid_d     = 1'b1;
                    tmo_d       = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW, WAIT_HIGH: begin
                if (tmo_q != C_TW'(G_TIMEOUT)) begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (tmo_d == C_TW'(G_TIMEOUT)) begin
                    timeout_d = 1'b1;
                end
                // Registered ready lags the toggle, so wait for it to fall first.
                if (state_q == WAIT_LOW) begin
                    if (!i_ready_A) begin
                        state_d = WAIT_HIGH;
                    end
                end else if (i_ready_A) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            last_q    <= C_IDW'(G_N_REQ - 1);
            grant_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_valid_A  = valid_q;
    assign o_data_A   = data_q;
    assign o_grant_id = grant_q;
    assign o_busy     = (state_q != IDLE);
    assign o_xfer_cnt = cnt_q;
    assign o_timeout  = timeout_q;

endmodule

`default_nettype wire

// File: doc/cdc_tx_arbiter.md
Name: cdc_tx_arbiter

Overview:
Round-robin arbiter and transfer sequencer that shares the source (A) side of the 2-phase CDC handshake between G_N_REQ requesters, all in the A clock domain. It accepts one word from the winning requester and issues a single-cycle valid to the CDC. It holds the data word stable until the 2-phase ack round-trip completes, then re-arbitrates. It also provides a transfer counter, a busy flag and a sticky timeout flag for a stalled ack.

Parameters:
G_N_REQ, 4, number of requesters (>=1)
G_WIDTH, 4, data word width; matches CDC G_WIDTH
G_TIMEOUT, 64, cycles allowed in WAIT_LOW+WAIT_HIGH before o_timeout sets (>=4)
G_CNT_WIDTH, 16, width of completed-transfer counter

Ports:
i_clk  in  1  A-domain clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  G_N_REQ  per-requester valid
i_req_data  in  G_N_REQ*G_WIDTH  requester k data at bits [k*G_WIDTH +: G_WIDTH]
o_req_ready  out  G_N_REQ  one-hot accept strobe; word transferred when valid&ready
o_valid_A  out  1  to CDC i_valid_A
o_data_A  out  G_WIDTH  to CDC i_data_A
i_ready_A  in  1  from CDC o_ready_A (registered, lags the internal ready by 1 cycle)
o_grant_id  out  max(1,$clog2(G_N_REQ))  index of the last accepted requester
o_busy  out  1  high in any state other than IDLE
o_xfer_cnt  out  G_CNT_WIDTH  count of completed round-trips, wraps modulo 2^G_CNT_WIDTH
o_timeout  out  1  sticky: ack round-trip exceeded G_TIMEOUT

Behaviour:
- Reset (async assert, sync-released use assumed upstream):
  - State is IDLE.
  - Round-robin pointer r_last = G_N_REQ-1, so requester 0 has first priority.
  - o_valid_A=0, o_data_A=0, o_grant_id=0, o_xfer_cnt=0, o_timeout=0, o_busy=0, o_req_ready=0.
  - Timeout counter = 0.
- FSM states are IDLE, SEND, WAIT_LOW and WAIT_HIGH.
- IDLE:
  - If i_ready_A=1 and any i_req_valid=1, the winner is the first valid requester scanning r_last+1, r_last+2, ... mod G_N_REQ.
  - o_req_ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge: latch the data word into the o_data_A register, set o_grant_id=winner, set r_last=winner, go to SEND.
  - If i_ready_A=0 (e.g. the first cycle after CDC reset), no grant is made.
- o_req_ready is 0 in every state other than IDLE.
- SEND:
  - o_valid_A=1 for exactly this one cycle; the CDC internal ready is guaranteed high here.
  - Unconditionally go to WAIT_LOW.
- WAIT_LOW:
  - Stay until i_ready_A=0, then go to WAIT_HIGH.
  - The CDC registered ready stays high for 1 cycle after the toggle, so the earliest exit is the 2nd cycle after SEND. This state prevents double-issue.
- WAIT_HIGH:
  - Stay until i_ready_A=1, then go to IDLE and increment o_xfer_cnt on that edge.
  - In the following IDLE cycle a new grant is possible immediately (back-to-back).
- o_data_A must remain constant from the SEND cycle until the WAIT_HIGH exit. The B side samples it asynchronously after the req toggle.
- o_valid_A is registered: it is high only in SEND and never in two consecutive cycles.
- Timeout:
  - The counter clears on entry to SEND and increments (saturating) every cycle in WAIT_LOW or WAIT_HIGH.
  - When it reaches G_TIMEOUT, o_timeout sets and stays set until reset.
  - The FSM keeps waiting; a toggle already issued cannot be aborted.
- A requester that drops valid in IDLE before it is granted is simply skipped. Requesters not granted keep valid asserted; the arbiter does not buffer them.
- Only one word is in flight at a time; maximum throughput is one word per CDC round-trip.
- G_N_REQ=1: the arbiter degenerates to a single-channel sequencer and o_grant_id stays 0.

Test Plan:
- Arbiter + cdc_2_phase (G_STAGES=2), clk A 10ns, clk B 13ns: requester 0 sends 0xA once -> one o_valid_A pulse; one o_valid_B pulse with o_data_B=0xA; o_xfer_cnt=1; o_busy low afterwards.
- All 4 requesters hold valid with data 0x1..0x4 -> grant order 0,1,2,3,0 and B receives 1,2,3,4,1; no requester granted twice before the others.
- Requester 2 only, 8 words back-to-back -> 8 B pulses in order, none lost or duplicated; o_valid_A never high in 2 consecutive cycles and never high outside SEND.
- Force i_ready_A stuck high (no CDC) after a grant -> FSM remains in WAIT_LOW; o_timeout=1 at G_TIMEOUT cycles after SEND; no second o_valid_A pulse.
- Assert i_rst_n low while in WAIT_HIGH -> all outputs return to reset values immediately (async); after release requester 0 wins first; o_xfer_cnt=0.
- Check o_data_A stability: change the granted requester's i_req_data every cycle after acceptance -> o_data_A and o_data_B equal the accepted value.
